jtframe_mr_upload: RTL and testbench

Responder for the MiSTer HPS upload direction: when the HPS saves a file (NVRAM, high-score table) it pulses `ioctl_rd` with a byte address, and this block fetches the matching data from a core-side RAM and presents it on `ioctl_din`. It sits between `hps_io` and the game's NVRAM read port, in the `clk_rom` domain. It mirrors the ROM-download path, which only writes into the core.

---
 rtl/jtframe_mr_upload.sv | 121 ++++++++++++
 tb/tb_jtframe_mr_upload.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_mr_upload.sv
// HPS upload responder: fetches core RAM bytes for ioctl_rd requests on INDEX; JTFRAME_MR_UPLOAD_WIDE_EN widens ioctl_din to 16 bits.
// Latency: ioctl_din updates 1+RAM_LAT edges after the accepted ioctl_rd (1+2*RAM_LAT edges when wide).
// No backpressure: a newer request restarts the fetch in flight; losing the session aborts to IDLE.
module jtframe_mr_upload #(
    parameter int         AW      = 12,
    parameter int         RAM_LAT = 1,
    parameter logic [7:0] INDEX   = 8'd2
) (
    input  logic          clk_rom,
    input  logic          rst_n,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
`ifdef JTFRAME_MR_UPLOAD_WIDE_EN
    output logic [15:0]   ioctl_din,
`else
    output logic [7:0]    ioctl_din,
`endif
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_dout,
    output logic          busy,
    output logic          uploading,
    output logic          upload_done
);
    typedef enum logic [1:0] { IDLE, FETCH, FETCH_HI } state_t;

    state_t      state;
    logic [24:0] addr;
    logic        issue;
    logic [1:0]  wait_cnt;
    logic        uploading_q;
    logic        session;
    logic        accept;
    logic [24:0] lo_addr;
    logic [24:0] hi_addr;
    logic        lo_ok;
    logic        hi_ok;
    logic        cur_ok;
    logic [7:0]  rd_byte;
`ifdef JTFRAME_MR_UPLOAD_WIDE_EN
    logic [7:0]  lo_byte;
`endif

    assign session = ioctl_upload && (ioctl_index == INDEX);
    assign accept  = ioctl_rd && session;
    assign lo_addr = addr;
    assign hi_addr = {addr[24:1], 1'b1};
    // Any address bit at or above AW means the byte is not backed by RAM
    assign lo_ok   = (lo_addr >> AW) == 25'd0;
    assign hi_ok   = (hi_addr >> AW) == 25'd0;
    assign cur_ok  = (state == FETCH_HI) ? hi_ok : lo_ok;
    assign rd_byte = cur_ok ? ram_dout : 8'hFF;

    always_ff @(posedge clk_rom) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            issue       <= 1'b0;
            wait_cnt    <= 2'd0;
            uploading_q <= 1'b0;
            ioctl_din   <= '0;
            ram_addr    <= '0;
            ram_rd      <= 1'b0;
            busy        <= 1'b0;
            uploading   <= 1'b0;
            upload_done <= 1'b0;
`ifdef JTFRAME_MR_UPLOAD_WIDE_EN
            lo_byte     <= 8'd0;
`endif
        end else begin
            uploading   <= session;
            uploading_q <= uploading;
            upload_done <= uploading_q && !uploading;
            ram_rd      <= 1'b0;
            // Accept beats capture: a restart discards the partial word in flight
            if (accept) begin
                state <= FETCH;
                issue <= 1'b1;
`ifdef JTFRAME_MR_UPLOAD_WIDE_EN
                addr  <= {ioctl_addr[24:1], 1'b0};
`else
                addr  <= ioctl_addr;
`endif
            end else if (state != IDLE) begin
                if (!session) begin
                    state <= IDLE;
                    issue <= 1'b0;
                    busy  <= 1'b0;
                end else if (issue) begin
                    issue    <= 1'b0;
                    busy     <= 1'b1;
                    wait_cnt <= 2'(RAM_LAT - 1);
                    ram_rd   <= lo_ok;
                    if (lo_ok) ram_addr <= lo_addr[AW-1:0];
                end else if (wait_cnt != 2'd0) begin
                    wait_cnt <= wait_cnt - 2'd1;
                end else begin
`ifdef JTFRAME_MR_UPLOAD_WIDE_EN
                    if (state == FETCH) begin
                        lo_byte  <= rd_byte;
                        state    <= FETCH_HI;
                        wait_cnt <= 2'(RAM_LAT - 1);
                        ram_rd   <= hi_ok;
                        if (hi_ok) ram_addr <= hi_addr[AW-1:0];
                    end else begin
                        ioctl_din <= {rd_byte, lo_byte};
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
`else
                    ioctl_din <= rd_byte;
                    busy      <= 1'b0;
                    state     <= IDLE;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_jtframe_mr_upload.sv
// Directed bench for jtframe_mr_upload: scoreboard of expected ioctl_din words plus timing/strobe checks.
module tb_jtframe_mr_upload;
`ifdef JTFRAME_MR_UPLOAD_WIDE_EN
    localparam int DW = 16, RAM_LAT = 2, NB = 2;
`else
    localparam int DW = 8, RAM_LAT = 1, NB = 1;
`endif
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [DW-1:0] ioctl_din;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [7:0]    ram_dout;
    logic          busy;
    logic          uploading;
    logic          upload_done;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    logic [AW-1:0] last_addr;
    logic [7:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0] ad1, ad2;
    logic [DW-1:0] sb [$];

    jtframe_mr_upload #(.AW(AW), .RAM_LAT(RAM_LAT), .INDEX(8'd2)) dut (
        .clk_rom(clk), .rst_n(rst_n), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ram_addr(ram_addr), .ram_rd(ram_rd),
        .ram_dout(ram_dout), .busy(busy), .uploading(uploading),
        .upload_done(upload_done)
    );

    always #5 clk = ~clk;

    // RAM model: data for an address held from edge k is sampled correctly at edge k+RAM_LAT
    always @(posedge clk) begin
        ad1 <= ram_addr;
        ad2 <= ad1;
    end
    assign ram_dout = mem[(RAM_LAT == 1) ? ram_addr : ((RAM_LAT == 2) ? ad1 : ad2)];

    always @(negedge clk) begin
        if (ram_rd === 1'b1) begin
            rd_cnt++;
            last_addr = ram_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_rng(input logic [24:0] a);
        return (a >> AW) == 25'd0;
    endfunction

    function automatic logic [7:0] model_byte(input logic [24:0] a);
        return in_rng(a) ? mem[a[AW-1:0]] : 8'hFF;
    endfunction

    function automatic logic [DW-1:0] model_word(input logic [24:0] a);
        logic [24:0] lo;
        logic [15:0] w;
        lo = (NB == 2) ? {a[24:1], 1'b0} : a;
        w  = {model_byte(lo | 25'd1), model_byte(lo)};
        return w[DW-1:0];
    endfunction

    task automatic request(input logic [24:0] a);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        step();
        ioctl_rd   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic sb_check(input string tag);
        logic [DW-1:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        check({tag, "_din"}, 32'(ioctl_din), 32'(e));
    endtask

    task automatic fetch(input logic [24:0] a, input string tag);
        logic [24:0] lo, hi;
        int exp_rd, base, n;
        lo     = (NB == 2) ? {a[24:1], 1'b0} : a;
        hi     = lo | 25'd1;
        exp_rd = int'(in_rng(lo)) + ((NB == 2) ? int'(in_rng(hi)) : 0);
        sb.push_back(model_word(a));
        base = rd_cnt;
        request(a);
        step();
        check({tag, "_busy1"}, 32'(busy), 32'd1);
        check({tag, "_rd1"}, 32'(ram_rd), 32'(in_rng(lo)));
        if (in_rng(lo)) check({tag, "_addr1"}, 32'(ram_addr), 32'(lo[AW-1:0]));
        wait_idle(20, n);
        check({tag, "_lat"}, n, NB * RAM_LAT);
        check({tag, "_rdcnt"}, rd_cnt - base, exp_rd);
        if (exp_rd == NB) check({tag, "_lastaddr"}, 32'(last_addr), 32'((NB == 2) ? hi[AW-1:0] : lo[AW-1:0]));
        sb_check(tag);
    endtask

    logic [24:0]   addrs [9];
    logic [DW-1:0] prev;
    int            n, base;
    logic          seen;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 7 + 3);
        mem[12'h010] = 8'h5A; mem[12'h011] = 8'hC3;
        mem[12'h020] = 8'h34; mem[12'h021] = 8'h12;
        mem[12'h030] = 8'h9E; mem[12'h031] = 8'h66;
        mem[12'h040] = 8'h11; mem[12'h041] = 8'h22;
        addrs = '{25'h010, 25'h1000, 25'h021, 25'h000, 25'hFFF, 25'h7FE, 25'h1FFFFFF, 25'h2FF0, 25'h801};

        // Reset with requests pulsing
        rst_n = 1'b0; ioctl_upload = 1'b1; ioctl_index = 8'd2; ioctl_rd = 1'b0; ioctl_addr = 25'h010;
        for (int i = 0; i < 4; i++) begin
            ioctl_rd = (i % 2 == 0);
            step();
        end
        check("rst_din", 32'(ioctl_din), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_rd", 32'(ram_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_uploading", 32'(uploading), 32'd0);
        check("rst_done", 32'(upload_done), 32'd0);
        ioctl_rd = 1'b0; rst_n = 1'b1;
        step(); step();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_rdcnt", rd_cnt, 0);
        check("uploading_on", 32'(uploading), 32'd1);

        // Directed fetches: in range, out of range, wide pairing, address edges
        for (int i = 0; i < 9; i++) begin
            fetch(addrs[i], $sformatf("fetch%0d", i));
            step();
        end

        // Restart while busy: only the newer address lands
        prev = ioctl_din;
        sb.push_back(model_word(25'h030));
        request(25'h040);
        step();
        check("restart_busy", 32'(busy), 32'd1);
        request(25'h030);
        check("restart_hold", 32'(ioctl_din), 32'(prev));
        step();
        wait_idle(20, n);
        check("restart_lat", n, NB * RAM_LAT);
        sb_check("restart");
        step();

        // Upload dropped mid-fetch, then session-end pulse
        prev = ioctl_din;
        request(25'h050);
        step();
        check("abort_busy1", 32'(busy), 32'd1);
        ioctl_upload = 1'b0;
        step();
        check("abort_busy0", 32'(busy), 32'd0);
        check("abort_din", 32'(ioctl_din), 32'(prev));
        check("uploading_fall", 32'(uploading), 32'd0);
        check("done_early", 32'(upload_done), 32'd0);
        step();
        check("done_pulse", 32'(upload_done), 32'd1);
        step();
        check("done_clear", 32'(upload_done), 32'd0);
        check("abort_hold", 32'(ioctl_din), 32'(prev));

        // Wrong index: ignored entirely
        ioctl_upload = 1'b1; ioctl_index = 8'd5;
        step(); step();
        check("widx_uploading", 32'(uploading), 32'd0);
        base = rd_cnt; seen = 1'b0;
        request(25'h010);
        for (int i = 0; i < 6; i++) begin
            seen = seen | busy | upload_done | uploading;
            step();
        end
        check("widx_quiet", 32'(seen), 32'd0);
        check("widx_rdcnt", rd_cnt - base, 0);
        check("widx_din", 32'(ioctl_din), 32'(prev));

        // Index change mid-fetch aborts and ends the session
        ioctl_index = 8'd2;
        step();
        check("idx_uploading", 32'(uploading), 32'd1);
        step();
        request(25'h020);
        step();
        ioctl_index = 8'd7;
        step();
        check("idxchg_busy", 32'(busy), 32'd0);
        check("idxchg_din", 32'(ioctl_din), 32'(prev));
        step();
        check("idxchg_done", 32'(upload_done), 32'd1);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
